mix_columns_seq: RTL and testbench



---
 rtl/aes_pkg.sv | 61 ++++++
 rtl/mix_column_word.sv | 46 ++++
 rtl/mix_columns_seq.sv | 129 ++++++++++++
 tb/tb_mix_columns_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers, widths and the MixColumns sequencer state type.
// Pure declarations: no latency.
// No flow control of its own.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mixcol_state_t;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] x);
    return xtime(x);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // Inverse coefficients are sums of x, 2x, 4x and 8x from a shared xtime chain.
  function automatic logic [7:0] gmul9(input logic [7:0] x);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(x)));
    return x8 ^ x;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] x);
    logic [7:0] x2;
    logic [7:0] x8;
    x2 = xtime(x);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ x;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] x);
    logic [7:0] x4;
    logic [7:0] x8;
    x4 = xtime(xtime(x));
    x8 = xtime(x4);
    return x8 ^ x4 ^ x;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] x);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Mixes one 32-bit AES column (row 0 in the top byte); inverse mix only with MIX_COLUMNS_INV_EN.
// Purely combinational: zero latency.
// No flow control; the parent sequences columns through it.
module mix_column_word
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_in,
`ifdef MIX_COLUMNS_INV_EN
  input  logic                 inv,
`endif
  output logic [AES_COL_W-1:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [AES_COL_W-1:0] fwd_col;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Forward mix: coefficients 2,3,1,1 rotated per row.
  always_comb begin
    fwd_col[31:24] = gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3;
    fwd_col[23:16] = gmul2(a1) ^ gmul3(a2) ^ a3 ^ a0;
    fwd_col[15:8]  = gmul2(a2) ^ gmul3(a3) ^ a0 ^ a1;
    fwd_col[7:0]   = gmul2(a3) ^ gmul3(a0) ^ a1 ^ a2;
  end

`ifdef MIX_COLUMNS_INV_EN
  logic [AES_COL_W-1:0] inv_col;

  // Inverse mix: coefficients 0e,0b,0d,09 rotated per row.
  always_comb begin
    inv_col[31:24] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
    inv_col[23:16] = gmul14(a1) ^ gmul11(a2) ^ gmul13(a3) ^ gmul9(a0);
    inv_col[15:8]  = gmul14(a2) ^ gmul11(a3) ^ gmul13(a0) ^ gmul9(a1);
    inv_col[7:0]   = gmul14(a3) ^ gmul11(a0) ^ gmul13(a1) ^ gmul9(a2);
  end

  assign col_out = inv ? inv_col : fwd_col;
`else
  assign col_out = fwd_col;
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative AES (Inv)MixColumns over 4/COLS_PER_CYCLE cycles; inverse built only with MIX_COLUMNS_INV_EN.
// Latency: out_valid rises 4/COLS_PER_CYCLE cycles after the accept edge; one state per N+1 cycles.
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready there for back-to-back accept.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] state_in,
  input  logic                   inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] state_out,
  output logic                   busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         NUM_GRPS = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_GRP = 2'(NUM_GRPS - 1);

  mixcol_state_t        state_q;
  logic [AES_STATE_W-1:0] src_q;
  logic [1:0]           grp_q;
  logic [AES_COL_W-1:0] src_cols   [4];
  logic [AES_COL_W-1:0] lane_in    [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0] lane_out   [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0] mixed_cols [4];
  logic [3:0]           col_wr;

`ifdef MIX_COLUMNS_INV_EN
  logic inv_q;
`else
  // Encrypt-only build: inv is accepted on the port but has no effect.
  logic inv_unused;
  assign inv_unused = inv;
`endif

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign src_cols[c]   = src_q[c*AES_COL_W +: AES_COL_W];
    // Column c is mixed by lane c%CPC while the counter sits on group c/CPC.
    assign mixed_cols[c] = lane_out[c % COLS_PER_CYCLE];
    assign col_wr[c]     = (grp_q == 2'(c / COLS_PER_CYCLE));
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
    logic [1:0] col_idx;
    // 2-bit wrap keeps the index valid for every legal COLS_PER_CYCLE.
    assign col_idx    = grp_q * 2'(COLS_PER_CYCLE) + 2'(k);
    assign lane_in[k] = src_cols[col_idx];

    mix_column_word u_mix (
      .col_in  (lane_in[k]),
`ifdef MIX_COLUMNS_INV_EN
      .inv     (inv_q),
`endif
      .col_out (lane_out[k])
    );
  end

  // Ready in IDLE, or in DONE when the held result is being taken this cycle.
  assign in_ready = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));

  // Sequencer: latch on accept, write one group per BUSY cycle, hold result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= '0;
      grp_q     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      state_out <= '0;
`ifdef MIX_COLUMNS_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            src_q   <= state_in;
            grp_q   <= '0;
            busy    <= 1'b1;
            state_q <= BUSY;
`ifdef MIX_COLUMNS_INV_EN
            inv_q   <= inv;
`endif
          end
        end
        BUSY: begin
          for (int c = 0; c < 4; c++) begin
            if (col_wr[c]) state_out[c*AES_COL_W +: AES_COL_W] <= mixed_cols[c];
          end
          if (grp_q == LAST_GRP) begin
            grp_q     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            grp_q <= grp_q + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              src_q   <= state_in;
              grp_q   <= '0;
              busy    <= 1'b1;
              state_q <= BUSY;
`ifdef MIX_COLUMNS_INV_EN
              inv_q   <= inv;
`endif
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4.
// Known vectors, handshake corners and random states against a GF(2^8) matrix model.
// Honours MIX_COLUMNS_INV_EN for expected inverse behaviour.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] state_in  [3];
  logic         inv_i     [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] state_out [3];
  logic         busy      [3];

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .state_in(state_in[0]), .inv(inv_i[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .state_out(state_out[0]), .busy(busy[0]));

  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .state_in(state_in[1]), .inv(inv_i[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .state_out(state_out[1]), .busy(busy[1]));

  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .state_in(state_in[2]), .inv(inv_i[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .state_out(state_out[2]), .busy(busy[2]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Shift-and-add GF(2^8) product, then polynomial reduction by 0x11b.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Circulant matrix product applied to each of the four columns.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic iv);
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (iv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else    cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gf_mul(cf[j], s[c*32 + 24 - 8*((row + j) % 4) +: 8]);
        r[c*32 + 24 - 8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at the negedge just after the accept edge; counts edges until out_valid.
  task automatic wait_done(input int d, output int lat, output logic [127:0] res);
    int k;
    k = 0;
    while (!out_valid[d] && k < 20) begin
      @(negedge clk);
      k++;
    end
    lat = k;
    res = state_out[d];
  endtask

  task automatic release_out(input int d);
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
  endtask

  task automatic do_op(input int d, input logic [127:0] s, input logic iv,
                       output logic [127:0] res, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    state_in[d] = s;
    inv_i[d]    = iv;
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    state_in[d] = rand128();
    inv_i[d]    = $urandom_range(0, 1) != 0;
    wait_done(d, lat, res);
    release_out(d);
  endtask

  typedef struct {
    logic [127:0] s;
    logic         iv;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res;
    logic [127:0] res2;
    logic [127:0] held;
    logic [127:0] s;
    logic         stable;
    logic         rdy_seen;
    int           lat;
    int           nlat [3];

    nlat = '{4, 2, 1};
    rst  = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      state_in[d]  = '0;
      inv_i[d]     = 1'b0;
      out_ready[d] = 1'b0;
    end

    tbl[0] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0,
               128'h046681e5_e0cb199a_48f8d37a_2806264c};
`ifdef MIX_COLUMNS_INV_EN
    tbl[1] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1,
               128'hdb135345_f20a225c_01010101_c6c6c6c6};
`else
    tbl[1] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1,
               ref_mix(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0)};
`endif
    tbl[2] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
               128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    tbl[3] = '{128'h0, 1'b0, 128'h0};
    tbl[4] = '{{16{8'hff}}, 1'b1, {16{8'hff}}};

    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_out_valid[%0d]", d), out_valid[d], 1'b0);
      check($sformatf("rst_busy[%0d]", d), busy[d], 1'b0);
      check($sformatf("rst_state_out[%0d]", d), state_out[d], 128'h0);
      check($sformatf("rst_in_ready[%0d]", d), in_ready[d], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("idle_in_ready[%0d]", d), in_ready[d], 1'b1);

    // Table vectors on every width, result and latency.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 5; i++) begin
        do_op(d, tbl[i].s, tbl[i].iv, res, lat);
        check($sformatf("tbl%0d_res[%0d]", i, d), res, tbl[i].exp);
        check($sformatf("tbl%0d_lat[%0d]", i, d), lat, nlat[d]);
      end
    end

    // Backpressure with back-to-back accept on the single-column instance.
    @(negedge clk);
    state_in[0] = tbl[0].s;
    inv_i[0]    = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_done(0, lat, held);
    check("bp_first_res", held, tbl[0].exp);
    stable   = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      state_in[0] = rand128();
      in_valid[0] = 1'b1;
      #1;
      if (in_ready[0]) rdy_seen = 1'b1;
      @(negedge clk);
      if (state_out[0] !== held || !out_valid[0]) stable = 1'b0;
    end
    check("bp_stable", stable, 1'b1);
    check("bp_in_ready_low", rdy_seen, 1'b0);
    s = rand128();
    state_in[0]  = s;
    inv_i[0]     = 1'b0;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    #1;
    check("b2b_in_ready", in_ready[0], 1'b1);
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    check("b2b_busy", busy[0], 1'b1);
    check("b2b_out_valid_drop", out_valid[0], 1'b0);
    wait_done(0, lat, res);
    check("b2b_res", res, ref_mix(s, 1'b0));
    check("b2b_lat", lat, 4);
    release_out(0);

    // Reset after group 1 has been written.
    @(negedge clk);
    state_in[0] = tbl[0].s;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy_before", busy[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid[0], 1'b0);
    check("midrst_state_out", state_out[0], 128'h0);
    check("midrst_busy", busy[0], 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready[0], 1'b1);
    do_op(0, tbl[2].s, 1'b0, res, lat);
    check("midrst_fresh_res", res, tbl[2].exp);
    check("midrst_fresh_lat", lat, 4);

    // in_valid during reset is not accepted.
    @(negedge clk);
    rst         = 1'b1;
    in_valid[0] = 1'b1;
    state_in[0] = tbl[0].s;
    @(negedge clk);
    check("rst_valid_busy", busy[0], 1'b0);
    rst         = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("rst_valid_busy_after", busy[0], 1'b0);
    check("rst_valid_out_valid", out_valid[0], 1'b0);

    // Random states: round trip where the inverse exists, forward-only otherwise.
    for (int i = 0; i < 1000; i++) begin
      s = rand128();
`ifdef MIX_COLUMNS_INV_EN
      do_op(0, s, 1'b0, res, lat);
      check($sformatf("rnd%0d_fwd", i), res, ref_mix(s, 1'b0));
      do_op(0, res, 1'b1, res2, lat);
      check($sformatf("rnd%0d_trip", i), res2, s);
`else
      do_op(0, s, $urandom_range(0, 1) != 0, res, lat);
      check($sformatf("rnd%0d_fwd", i), res, ref_mix(s, 1'b0));
`endif
    end

    // Random states on the wider instances.
    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 60; i++) begin
        logic iv;
        s  = rand128();
        iv = $urandom_range(0, 1) != 0;
        do_op(d, s, iv, res, lat);
`ifdef MIX_COLUMNS_INV_EN
        check($sformatf("rndw%0d_%0d", d, i), res, ref_mix(s, iv));
`else
        check($sformatf("rndw%0d_%0d", d, i), res, ref_mix(s, 1'b0));
`endif
        check($sformatf("rndw%0d_%0d_lat", d, i), lat, nlat[d]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
